param_alu: RTL

Parametrised, registered ALU with valid/ready handshaking on both sides. It is the next generation of the 8-bit PowerALU and supports WIDTH-bit operands and the same 4-bit opcode space. It adds signed/unsigned flags, rotates, and iterative multi-cycle multiply and divide. It sits between the operand register file and the writeback stage of the datapath.

---
 rtl/param_alu_pkg.sv | 28 ++
 rtl/param_alu_if.sv | 28 ++
 rtl/param_alu_muldiv.sv | 79 +++++++
 rtl/param_alu.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/param_alu_pkg.sv
// Shared types for param_alu: opcode map, sequencing states and result flags.
package param_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
    OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_SHL = 4'd6,  OP_SHR = 4'd7,
    OP_SAR = 4'd8,  OP_ROL = 4'd9,  OP_ROR = 4'd10, OP_INC = 4'd11,
    OP_DEC = 4'd12, OP_SLT = 4'd13, OP_MUL = 4'd14, OP_DIV = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

  function automatic logic isMulDiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/param_alu_if.sv
// Operand/result handshake bundle between the register file, param_alu and writeback.
interface param_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, opcode, A, B, out_ready,
    input  in_ready, out_valid, result, result_hi, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, opcode, A, B, out_ready,
    output in_ready, out_valid, result, result_hi, carry, overflow, zero, negative
  );
endinterface

// File: rtl/param_alu_muldiv.sv
// Iterative engine: shift-add unsigned multiply and restoring unsigned divide, one bit per cycle.
module param_alu_muldiv #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             overflow
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] hiQ, loQ, opQ, hiD, loD, shifted;
  logic [WIDTH:0]   addSum;
  logic             isDivQ, busyQ, doneQ, geq;
  logic [SHW-1:0]   cntQ;

  // hi:lo is the product accumulator for MUL, remainder:quotient for DIV.
  always_comb begin
    hiD     = hiQ;
    loD     = loQ;
    addSum  = {1'b0, hiQ} + (loQ[0] ? {1'b0, opQ} : '0);
    shifted = {hiQ[MSB-1:0], loQ[MSB]};
    geq     = ({hiQ[MSB], shifted} >= {1'b0, opQ});
    if (isDivQ) begin
      hiD = geq ? (shifted - opQ) : shifted;
      loD = {loQ[MSB-1:0], geq};
    end else begin
      hiD = addSum[WIDTH:1];
      loD = {addSum[0], loQ[MSB:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hiQ    <= '0;
      loQ    <= '0;
      opQ    <= '0;
      isDivQ <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      cntQ   <= '0;
    end else if (enable) begin
      doneQ <= 1'b0;
      if (start) begin
        hiQ    <= '0;
        loQ    <= a;
        opQ    <= b;
        isDivQ <= isDiv;
        busyQ  <= 1'b1;
        cntQ   <= SHW'(WIDTH - 1);
      end else if (busyQ) begin
        hiQ  <= hiD;
        loQ  <= loD;
        cntQ <= cntQ - SHW'(1);
        if (cntQ == '0) begin
          busyQ <= 1'b0;
          doneQ <= 1'b1;
        end
      end
    end
  end

  assign busy      = busyQ;
  assign done      = doneQ;
  assign result    = loQ;
  assign result_hi = hiQ;
  assign carry     = !isDivQ && (hiQ != '0);
  assign overflow  = isDivQ && (opQ == '0);
endmodule

// File: rtl/param_alu.sv
// Registered WIDTH-bit ALU with valid/ready on both sides.
// PARAM_ALU_MULDIV_EN adds the iterative MUL/DIV engine; without it opcodes 14/15 flag overflow.
//   state   | meaning
//   ST_IDLE | no result pending, ready for an operation
//   ST_CALC | MUL/DIV engine iterating, input stalled
//   ST_DONE | result registered, waiting for out_ready
module param_alu
  import param_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        reset,
  input logic        enable,
  param_alu_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  state_t           stateQ, stateD;
  logic             armedQ, inReady, accept, isMd, loadAlu, loadEng;
  logic [WIDTH-1:0] aluRes, resQ, hiQ;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  flags_t           aluFlags, engFlags, flagsQ;
  logic             engBusy, engDone, engCarry, engOvf;
  logic [WIDTH-1:0] engRes, engHi;

`ifdef PARAM_ALU_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;

  param_alu_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) uMulDiv (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .start     (accept && isMd),
    .isDiv     (bus.opcode == OP_DIV),
    .a         (bus.A),
    .b         (bus.B),
    .busy      (engBusy),
    .done      (engDone),
    .result    (engRes),
    .result_hi (engHi),
    .carry     (engCarry),
    .overflow  (engOvf)
  );
`else
  localparam bit MULDIV_EN = 1'b0;

  assign engBusy  = 1'b0;
  assign engDone  = 1'b0;
  assign engRes   = '0;
  assign engHi    = '0;
  assign engCarry = 1'b0;
  assign engOvf   = 1'b0;
`endif

  // armedQ keeps in_ready low until the first edge after reset release.
  assign inReady = armedQ && !engBusy &&
                   ((stateQ == ST_IDLE) || ((stateQ == ST_DONE) && bus.out_ready));
  assign accept  = bus.in_valid && inReady && enable;
  assign isMd    = MULDIV_EN && isMulDiv(bus.opcode);

  always_comb begin
    aluRes   = '0;
    aluFlags = '0;
    sum      = '0;
    shamt    = bus.B[SHW-1:0];
    case (bus.opcode)
      OP_ADD: begin
        sum = {1'b0, bus.A} + {1'b0, bus.B};
        aluRes = sum[MSB:0];
        aluFlags.carry = sum[WIDTH];
        aluFlags.overflow = (bus.A[MSB] == bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
      end
      OP_SUB: begin
        sum = {1'b0, bus.A} - {1'b0, bus.B};
        aluRes = sum[MSB:0];
        aluFlags.carry = sum[WIDTH];
        aluFlags.overflow = (bus.A[MSB] != bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
      end
      OP_AND: aluRes = bus.A & bus.B;
      OP_OR:  aluRes = bus.A | bus.B;
      OP_XOR: aluRes = bus.A ^ bus.B;
      OP_NOT: aluRes = ~bus.A;
      OP_SHL: aluRes = bus.A << shamt;
      OP_SHR: aluRes = bus.A >> shamt;
      OP_SAR: aluRes = $unsigned($signed(bus.A) >>> shamt);
      OP_ROL: aluRes = (bus.A << shamt) | (bus.A >> (WIDTH - int'(shamt)));
      OP_ROR: aluRes = (bus.A >> shamt) | (bus.A << (WIDTH - int'(shamt)));
      OP_INC: begin
        sum = {1'b0, bus.A} + (WIDTH+1)'(1);
        aluRes = sum[MSB:0];
        aluFlags.carry = sum[WIDTH];
        aluFlags.overflow = !bus.A[MSB] && sum[MSB];
      end
      OP_DEC: begin
        sum = {1'b0, bus.A} - (WIDTH+1)'(1);
        aluRes = sum[MSB:0];
        aluFlags.carry = sum[WIDTH];
        aluFlags.overflow = bus.A[MSB] && !sum[MSB];
      end
      OP_SLT: aluRes = {{MSB{1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      // Only reached as single-cycle ops when the engine is not built.
      OP_MUL, OP_DIV: aluFlags.overflow = 1'b1;
    endcase
    aluFlags.zero     = (aluRes == '0);
    aluFlags.negative = aluRes[MSB];
  end

  always_comb begin
    engFlags.carry    = engCarry;
    engFlags.overflow = engOvf;
    engFlags.zero     = (engRes == '0);
    engFlags.negative = engRes[MSB];
  end

  always_comb begin
    stateD  = stateQ;
    loadAlu = 1'b0;
    loadEng = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (accept) begin
          stateD  = isMd ? ST_CALC : ST_DONE;
          loadAlu = !isMd;
        end
      end
      ST_CALC: begin
        if (enable && engDone) begin
          stateD  = ST_DONE;
          loadEng = 1'b1;
        end
      end
      ST_DONE: begin
        if (enable && bus.out_ready) begin
          if (accept) begin
            stateD  = isMd ? ST_CALC : ST_DONE;
            loadAlu = !isMd;
          end else begin
            stateD = ST_IDLE;
          end
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= ST_IDLE;
      armedQ <= 1'b0;
      resQ   <= '0;
      hiQ    <= '0;
      flagsQ <= '0;
    end else begin
      stateQ <= stateD;
      armedQ <= 1'b1;
      if (loadAlu) begin
        resQ   <= aluRes;
        hiQ    <= '0;
        flagsQ <= aluFlags;
      end else if (loadEng) begin
        resQ   <= engRes;
        hiQ    <= engHi;
        flagsQ <= engFlags;
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = (stateQ == ST_DONE);
  assign bus.result    = resQ;
  assign bus.result_hi = hiQ;
  assign bus.carry     = flagsQ.carry;
  assign bus.overflow  = flagsQ.overflow;
  assign bus.zero      = flagsQ.zero;
  assign bus.negative  = flagsQ.negative;
endmodule
